// File: rtl/emissor_snoop_pkg.sv
// Shared definitions for the MSI snooping pair (emissor_snoop and its receptor).
//
// Contents:
//   line_state_e : MSI line state encodings (INVALID, SHARED, EXCLUSIVE)
//   bus_msg_e    : bus message codes driven on mensagemBus (BUS_NONE = idle bus)
//   snoop_apply  : line state after a receptor-reported invalidate/downgrade
//   is_miss_msg  : true for messages that count as a cache miss on the bus
package emissor_snoop_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10
  } line_state_e;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'b000,
    WRITE_MISS_BUS = 3'b001,
    READ_MISS_BUS  = 3'b010,
    INVALIDATE_BUS = 3'b011
  } bus_msg_e;

  // An invalidate dominates a simultaneous downgrade; a downgrade only
  // affects an EXCLUSIVE line.
  function automatic line_state_e snoop_apply(input line_state_e cur,
                                              input logic        inv,
                                              input logic        shr);
    line_state_e nxt;
    nxt = cur;
    if (inv) begin
      nxt = INVALID;
    end else if (shr && (cur == EXCLUSIVE)) begin
      nxt = SHARED;
    end
    return nxt;
  endfunction

  function automatic logic is_miss_msg(input bus_msg_e msg);
    return (msg == READ_MISS_BUS) || (msg == WRITE_MISS_BUS);
  endfunction

endpackage

// File: rtl/emissor_snoop_grant_wait_timer.sv
// Grant-wait timer: counts cycles a bus request has gone ungranted.
//
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   enable  : count this cycle (request pending, no grant)
//   clear   : synchronous clear, has priority over enable
//   timeout : high in the cycle whose count step reaches MAX_WAIT
module emissor_snoop_grant_wait_timer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flagged one cycle early so the request is dropped exactly after
  // MAX_WAIT ungranted cycles.
  assign timeout = enable && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/emissor_snoop.sv
// Processor-side MSI controller for a single cache line.
//
// Classifies CPU requests against the line state, obtains the bus through a
// request/grant handshake (with a one-cycle backoff after MAX_WAIT ungranted
// cycles), drives one bus message, then pulses cpuReady and updates the
// line state. Snoop results from the receptor are folded in while the
// controller does not own the bus.
//
// Ports:
//   clock, reset   : clock (rising edge) and asynchronous active-low reset
//   cpuValid       : CPU request strobe, sampled in IDLE only
//   cpuWrite       : 1 = write, 0 = read
//   cpuHit         : tag match for the requested address
//   busGrant       : arbiter grant
//   snoopInvalida  : receptor invalidated the line
//   snoopShared    : receptor downgraded EXCLUSIVE -> SHARED
//   mensagemBus    : bus message, non-zero only in the drive cycle
//   busReq         : bus request
//   writeBack      : write-back strobe when an EXCLUSIVE line is evicted
//   cpuReady       : one-cycle completion pulse
//   estado         : line state (INVALID/SHARED/EXCLUSIVE)
//   missCount      : saturating miss counter (only with MISS_COUNT_EN)
//
// Build option: define MISS_COUNT_EN to add the missCount output.
module emissor_snoop
  import emissor_snoop_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuValid,
  input  logic        cpuWrite,
  input  logic        cpuHit,
  input  logic        busGrant,
  input  logic        snoopInvalida,
  input  logic        snoopShared,
  output logic [2:0]  mensagemBus,
  output logic        busReq,
  output logic        writeBack,
  output logic        cpuReady,
  output logic [1:0]  estado
`ifdef MISS_COUNT_EN
  ,
  output logic [15:0] missCount
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StBackoff,
    StDrive,
    StDone
  } fsm_e;

  fsm_e        state_q, state_d;
  line_state_e estado_q, estado_d;
  bus_msg_e    pending_q, pending_d;
  logic        evict_q, evict_d;

  bus_msg_e    msg_q;
  logic        bus_req_q;
  logic        write_back_q;
  logic        cpu_ready_q;

  line_state_e est_snooped;
  logic        snoop_window;
  logic        timer_en;
  logic        timer_clr;
  logic        timeout;

  emissor_snoop_grant_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_grant_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (timer_en),
    .clear   (timer_clr),
    .timeout (timeout)
  );

  // Snoops are ignored while this controller owns the bus (DRIVE/DONE).
  assign snoop_window = (state_q == StIdle) || (state_q == StReq) || (state_q == StBackoff);
  assign est_snooped  = snoop_apply(estado_q, snoopInvalida, snoopShared);

  always_comb begin
    state_d   = state_q;
    estado_d  = estado_q;
    pending_d = pending_q;
    evict_d   = evict_q;
    timer_en  = 1'b0;
    timer_clr = 1'b1;

    if (snoop_window) begin
      estado_d = est_snooped;
    end

    unique case (state_q)
      StIdle: begin
        if (cpuValid) begin
          // Classification uses the post-snoop state of this same cycle.
          pending_d = BUS_NONE;
          evict_d   = 1'b0;
          if (!cpuWrite && cpuHit && (est_snooped != INVALID)) begin
            state_d = StDone;
          end else if (cpuWrite && cpuHit && (est_snooped == EXCLUSIVE)) begin
            state_d = StDone;
          end else if (cpuWrite && cpuHit && (est_snooped == SHARED)) begin
            pending_d = INVALIDATE_BUS;
            state_d   = StReq;
          end else begin
            pending_d = cpuWrite ? WRITE_MISS_BUS : READ_MISS_BUS;
            evict_d   = !cpuHit && (est_snooped == EXCLUSIVE);
            state_d   = StReq;
          end
        end
      end

      StReq: begin
        // Losing the shared copy turns the pending upgrade into a full miss.
        if (snoopInvalida && (pending_q == INVALIDATE_BUS)) begin
          pending_d = WRITE_MISS_BUS;
        end
        if (busGrant) begin
          state_d = StDrive;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
          if (timeout) begin
            state_d = StBackoff;
          end
        end
      end

      StBackoff: begin
        if (snoopInvalida && (pending_q == INVALIDATE_BUS)) begin
          pending_d = WRITE_MISS_BUS;
        end
        state_d = StReq;
      end

      StDrive: begin
        state_d = StDone;
        // The new state is visible in the DONE cycle alongside cpuReady.
        unique case (pending_q)
          READ_MISS_BUS:                  estado_d = SHARED;
          WRITE_MISS_BUS, INVALIDATE_BUS: estado_d = EXCLUSIVE;
          default:                        estado_d = estado_q;
        endcase
      end

      StDone: begin
        state_d   = StIdle;
        pending_d = BUS_NONE;
        evict_d   = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      estado_q  <= INVALID;
      pending_q <= BUS_NONE;
      evict_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      estado_q  <= estado_d;
      pending_q <= pending_d;
      evict_q   <= evict_d;
    end
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_q        <= BUS_NONE;
      bus_req_q    <= 1'b0;
      write_back_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
    end else begin
      msg_q        <= (state_d == StDrive) ? pending_d : BUS_NONE;
      bus_req_q    <= (state_d == StReq) || (state_d == StDrive);
      write_back_q <= (state_d == StDrive) && evict_d;
      cpu_ready_q  <= (state_d == StDone);
    end
  end

  assign mensagemBus = msg_q;
  assign busReq      = bus_req_q;
  assign writeBack   = write_back_q;
  assign cpuReady    = cpu_ready_q;
  assign estado      = estado_q;

`ifdef MISS_COUNT_EN
  logic [15:0] miss_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_count_q <= '0;
    end else if ((state_q == StDrive) && is_miss_msg(pending_q) &&
                 (miss_count_q != 16'hFFFF)) begin
      miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign missCount = miss_count_q;
`endif

endmodule

// File: tb/tb_emissor_snoop.sv
// Self-checking bench for emissor_snoop: a reference model of the line state
// pushes expected bus messages and completion states into queues; they are
// popped and compared as the DUT drives the bus and pulses cpuReady.
module tb_emissor_snoop;

  localparam logic [1:0] L_INV = 2'b00;
  localparam logic [1:0] L_SHR = 2'b01;
  localparam logic [1:0] L_EXC = 2'b10;
  localparam logic [2:0] M_WM  = 3'b001;
  localparam logic [2:0] M_RM  = 3'b010;
  localparam logic [2:0] M_IV  = 3'b011;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpuValid, cpuWrite, cpuHit, busGrant, snoopInvalida, snoopShared;
  logic [2:0] mensagemBus;
  logic       busReq, writeBack, cpuReady;
  logic [1:0] estado;
`ifdef MISS_COUNT_EN
  logic [15:0] missCount;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] msg;
    logic       wb;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [1:0] done_q[$];
  logic [1:0] m_est;

  always #5 clock = ~clock;

  emissor_snoop dut (
    .clock         (clock),
    .reset         (reset),
    .cpuValid      (cpuValid),
    .cpuWrite      (cpuWrite),
    .cpuHit        (cpuHit),
    .busGrant      (busGrant),
    .snoopInvalida (snoopInvalida),
    .snoopShared   (snoopShared),
    .mensagemBus   (mensagemBus),
    .busReq        (busReq),
    .writeBack     (writeBack),
    .cpuReady      (cpuReady),
    .estado        (estado)
`ifdef MISS_COUNT_EN
    ,
    .missCount     (missCount)
`endif
  );

  // Drives one request (with optional same-cycle snoops), updates the model
  // and pushes the expectations. Returns whether a bus transaction is due.
  task automatic issue(input logic wr, input logic hit, input logic snp_sh,
                       input logic snp_inv, output logic bus);
    logic [1:0] e;
    bus_exp_t   b;
    e = m_est;
    if (snp_inv) e = L_INV;
    else if (snp_sh && e == L_EXC) e = L_SHR;
    bus  = 1'b1;
    b.wb = 1'b0;
    if (!wr && hit && e != L_INV) begin
      bus = 1'b0;
    end else if (wr && hit && e == L_EXC) begin
      bus = 1'b0;
    end else if (wr && hit && e == L_SHR) begin
      b.msg = M_IV;
      e     = L_EXC;
    end else begin
      b.wb  = !hit && (e == L_EXC);
      b.msg = wr ? M_WM : M_RM;
      e     = wr ? L_EXC : L_SHR;
    end
    if (bus) bus_q.push_back(b);
    done_q.push_back(e);
    m_est = e;
    cpuValid = 1'b1; cpuWrite = wr; cpuHit = hit;
    snoopShared = snp_sh; snoopInvalida = snp_inv;
    @(posedge clock); #1;
    cpuValid = 1'b0; snoopShared = 1'b0; snoopInvalida = 1'b0;
  endtask

  // Runs the handshake until cpuReady, checking bus traffic and completion.
  // Grant is given on the (delay+1)-th cycle busReq is seen high.
  task automatic run_txn(input int delay, input int snoop_cyc, input int exp_lat,
                         input int exp_req0);
    int       seen = 0;
    int       cyc  = 0;
    bit       done = 0;
    bus_exp_t b;
    logic [1:0] de;
    while (cyc < 200 && !done) begin
      busGrant = busReq && (seen >= delay);
      if (busReq) seen++;
      snoopInvalida = (cyc == snoop_cyc);
      @(negedge clock);
      if (cyc == 0 && exp_req0 >= 0) begin
        checks++;
        if (busReq !== exp_req0[0]) begin
          errors++;
          $display("FAIL first_busReq: got %b, expected %0d", busReq, exp_req0);
        end
      end
      if (mensagemBus !== 3'b000) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: mensagemBus=%b, expected 000", mensagemBus);
        end else begin
          b = bus_q.pop_front();
          if (mensagemBus !== b.msg || writeBack !== b.wb || busReq !== 1'b1) begin
            errors++;
            $display("FAIL bus_msg: got msg=%b wb=%b req=%b, expected msg=%b wb=%b req=1",
                     mensagemBus, writeBack, busReq, b.msg, b.wb);
          end
        end
      end else if (writeBack !== 1'b0) begin
        checks++; errors++;
        $display("FAIL wb_alone: writeBack=%b with mensagemBus=000, expected 0", writeBack);
      end
      if (cpuReady === 1'b1) begin
        done = 1;
        de = (done_q.size() != 0) ? done_q.pop_front() : 2'bxx;
        checks++;
        if (estado !== de || busReq !== 1'b0) begin
          errors++;
          $display("FAIL done_state: got estado=%b busReq=%b, expected estado=%b busReq=0",
                   estado, busReq, de);
        end
        if (exp_lat >= 0) begin
          checks++;
          if (cyc != exp_lat) begin
            errors++;
            $display("FAIL latency: cpuReady at cycle %0d, expected %0d", cyc, exp_lat);
          end
        end
        checks++;
        if (bus_q.size() != 0) begin
          errors++;
          $display("FAIL bus_missing: %0d expected messages not seen, expected 0",
                   bus_q.size());
          bus_q.delete();
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    busGrant = 1'b0; snoopInvalida = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no cpuReady within 200 cycles, expected completion");
      done_q.delete(); bus_q.delete();
    end else begin
      @(negedge clock);
      checks++;
      if (cpuReady !== 1'b0 || busReq !== 1'b0 || mensagemBus !== 3'b000) begin
        errors++;
        $display("FAIL idle_after: got ready=%b req=%b msg=%b, expected 0 0 000",
                 cpuReady, busReq, mensagemBus);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (mensagemBus !== 3'b000 || busReq !== 1'b0 || writeBack !== 1'b0 ||
        cpuReady !== 1'b0 || estado !== 2'b00) begin
      errors++;
      $display("FAIL %s: got msg=%b req=%b wb=%b ready=%b estado=%b, expected all zero",
               name, mensagemBus, busReq, writeBack, cpuReady, estado);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_quiet("reset_state");
    reset = 1'b1;
    m_est = L_INV;
    @(posedge clock); #1;
  endtask

  task automatic test_read_miss();
    logic bus;
    issue(1'b0, 1'b0, 1'b0, 1'b0, bus);
    run_txn(0, -1, 2, 1);
  endtask

  task automatic test_hits();
    logic bus;
    issue(1'b0, 1'b1, 1'b0, 1'b0, bus);   // read hit on SHARED
    run_txn(0, -1, 0, 0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, bus);   // upgrade SHARED -> EXCLUSIVE
    run_txn(0, -1, 2, 1);
    issue(1'b1, 1'b1, 1'b0, 1'b0, bus);   // write hit on EXCLUSIVE
    run_txn(0, -1, 0, 0);
  endtask

  task automatic test_evict();
    logic bus;
    issue(1'b1, 1'b0, 1'b0, 1'b0, bus);   // write miss evicting EXCLUSIVE
    run_txn(0, -1, 2, 1);
    issue(1'b0, 1'b0, 1'b0, 1'b0, bus);   // read miss evicting, late grant
    run_txn(3, -1, 5, 1);
  endtask

  task automatic test_snoop_idle();
    logic bus;
    issue(1'b1, 1'b1, 1'b0, 1'b0, bus);   // SHARED -> EXCLUSIVE
    run_txn(0, -1, 2, 1);
    issue(1'b1, 1'b1, 1'b1, 1'b0, bus);   // downgrade same cycle: upgrade again
    run_txn(1, -1, 3, 1);
    snoopInvalida = 1'b1; snoopShared = 1'b1;
    @(posedge clock); #1;
    snoopInvalida = 1'b0; snoopShared = 1'b0;
    m_est = L_INV;
    @(negedge clock);
    checks++;
    if (estado !== L_INV) begin
      errors++;
      $display("FAIL both_snoops: got estado=%b, expected 00", estado);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backoff();
    logic bus;
    logic exp_req;
    issue(1'b0, 1'b0, 1'b0, 1'b0, bus);
    busGrant = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      exp_req = ((i % 16) != 15);
      checks++;
      if (busReq !== exp_req || mensagemBus !== 3'b000) begin
        errors++;
        $display("FAIL backoff_c%0d: got req=%b msg=%b, expected req=%b msg=000",
                 i, busReq, mensagemBus, exp_req);
      end
      @(posedge clock); #1;
    end
    run_txn(0, -1, 2, 1);
  endtask

  task automatic test_snoop_pending();
    logic     bus;
    bus_exp_t b;
    issue(1'b1, 1'b1, 1'b0, 1'b0, bus);
    // Invalidation while waiting turns the upgrade into a write miss.
    bus_q.delete();
    b.msg = M_WM; b.wb = 1'b0;
    bus_q.push_back(b);
    run_txn(5, 2, 7, 1);
  endtask

  task automatic test_reset_drive();
    logic bus;
    issue(1'b1, 1'b0, 1'b0, 1'b0, bus);   // EXCLUSIVE write miss: wb expected
    busGrant = 1'b1;
    @(posedge clock); #1;
    busGrant = 1'b0;
    @(negedge clock);
    checks++;
    if (mensagemBus !== M_WM || writeBack !== 1'b1) begin
      errors++;
      $display("FAIL drive_before_reset: got msg=%b wb=%b, expected 001 1",
               mensagemBus, writeBack);
    end
    #2 reset = 1'b0;
    #1 check_quiet("reset_mid_drive");
    bus_q.delete(); done_q.delete();
    m_est = L_INV;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    issue(1'b0, 1'b0, 1'b0, 1'b0, bus);
    run_txn(0, -1, 2, 1);
  endtask

  task automatic test_back_to_back();
    logic bus;
    logic wr, hit, sh;
    int   d;
    for (int k = 0; k < 14; k++) begin
      wr  = 1'($urandom_range(0, 1));
      hit = 1'($urandom_range(0, 1));
      sh  = ($urandom_range(0, 3) == 0);
      d   = int'($urandom_range(0, 3));
      issue(wr, hit, sh, 1'b0, bus);
      run_txn(d, -1, bus ? d + 2 : 0, bus ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b0; cpuValid = 1'b0; cpuWrite = 1'b0; cpuHit = 1'b0;
    busGrant = 1'b0; snoopInvalida = 1'b0; snoopShared = 1'b0;
    m_est = L_INV;
    test_reset();
    test_read_miss();
    test_hits();
    test_evict();
    test_snoop_idle();
    test_backoff();
    test_snoop_pending();
    test_reset_drive();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
